// File: rtl/tfi_pkg.sv
// tfi_pkg: shared constants and types for the twiddle-factor index generator.
//   LOG2N_DEFAULT : default log2 of the FFT size (64-point transform)
//   N_HALF        : indices emitted per stage sequence for the default size
//   tfi_idx_t     : twiddle ROM index type for the default size
//   tfi_state_e   : control FSM states
package tfi_pkg;

   localparam int LOG2N_DEFAULT = 6;
   localparam int N_HALF        = 1 << (LOG2N_DEFAULT - 1);

   typedef logic [LOG2N_DEFAULT-1:0] tfi_idx_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tfi_state_e;

endpackage

// File: rtl/tfi_stage_encoder.sv
// tfi_stage_encoder: combinational one-hot to binary priority encoder.
// The lowest set bit wins, so a multi-hot select degrades to its lowest stage.
//   sel  : W-bit stage select (one-hot expected)
//   idx  : index of the lowest set bit of sel (0 when sel is zero)
//   zero : high when no bit of sel is set
module tfi_stage_encoder #(
   parameter int W  = 6,
   parameter int KW = $clog2(W)
) (
   input  logic [W-1:0]  sel,
   output logic [KW-1:0] idx,
   output logic          zero
);

   always_comb begin
      idx  = '0;
      zero = 1'b1;
      // Scan from the top down so the lowest set bit is the last to assign.
      for (int b = W - 1; b >= 0; b--) begin
         if (sel[b]) begin
            idx  = KW'(b);
            zero = 1'b0;
         end
      end
   end

endmodule

// File: rtl/twiddle_factor_index.sv
// twiddle_factor_index: twiddle ROM index sequencer for one radix-2 FFT stage.
// A start pulse latches the stage (lowest set bit of the one-hot select) and
// the block then emits N/2 registered indices, one per clock.
// Build option: define TFI_DIF_EN for decimation-in-frequency ordering,
// out = (i mod 2^(LOG2N-1-k)) << k; otherwise DIT ordering,
// out = (i mod 2^k) << (LOG2N-1-k).
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   stage : one-hot stage select, sampled only when start is accepted
//   start : single-cycle request to begin a stage sequence
//   out   : registered twiddle ROM index
//   valid : out holds a sequence index this cycle
//   done  : high together with the last valid index of a sequence
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start with a non-zero stage; outputs held at 0
// RUN   | emitting indices; leaves on the edge after the done cycle
module twiddle_factor_index
   import tfi_pkg::*;
#(
   parameter int LOG2N = LOG2N_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LOG2N-1:0] stage,
   input  logic             start,
   output logic [LOG2N-1:0] out,
   output logic             valid,
   output logic             done
);

   localparam int KW = $clog2(LOG2N);
   localparam int CW = LOG2N - 1;

   tfi_state_e       state_q, state_n;
   logic [CW-1:0]    cnt_q, cnt_n;
   logic [KW-1:0]    k_q, k_n;
   logic [LOG2N-1:0] out_n;
   logic             valid_n, done_n;

   logic [KW-1:0]    enc_k;
   logic             enc_zero;

   logic [LOG2N-1:0] iw, mask, idx_val;
   logic [KW-1:0]    sh;

   tfi_stage_encoder #(
      .W  (LOG2N),
      .KW (KW)
   ) u_enc (
      .sel  (stage),
      .idx  (enc_k),
      .zero (enc_zero)
   );

   assign iw = {1'b0, cnt_q};
   assign sh = KW'(LOG2N - 1) - k_q;

`ifdef TFI_DIF_EN
   assign mask    = (LOG2N'(1) << sh) - LOG2N'(1);
   assign idx_val = (iw & mask) << k_q;
`else
   assign mask    = (LOG2N'(1) << k_q) - LOG2N'(1);
   assign idx_val = (iw & mask) << sh;
`endif

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      k_n     = k_q;
      out_n   = '0;
      valid_n = 1'b0;
      done_n  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !enc_zero) begin
               // Index 0 is always 0, so the first output needs no shift logic.
               state_n = RUN;
               k_n     = enc_k;
               cnt_n   = CW'(1);
               valid_n = 1'b1;
            end
         end
         RUN: begin
            if (done) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               out_n   = idx_val;
               valid_n = 1'b1;
               done_n  = &cnt_q;
               cnt_n   = cnt_q + CW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         k_q     <= '0;
         out     <= '0;
         valid   <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         k_q     <= k_n;
         out     <= out_n;
         valid   <= valid_n;
         done    <= done_n;
      end
   end

endmodule

// File: tb/tb_twiddle_factor_index.sv
// tb_twiddle_factor_index: directed bench with a scoreboard queue of expected
// (index, done) pairs, filled when a start is driven and drained by a monitor
// sampling on the falling clock edge.
module tb_twiddle_factor_index;
   import tfi_pkg::*;

   typedef struct {
      logic [5:0] idx;
      logic       last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] stage = '0;
   logic       start = 1'b0;
   tfi_idx_t   out;
   logic       valid;
   logic       done;

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   twiddle_factor_index #(.LOG2N(6)) dut (
      .clk   (clk),
      .rst   (rst),
      .stage (stage),
      .start (start),
      .out   (out),
      .valid (valid),
      .done  (done)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] model(input logic [5:0] st, input int i);
      int k = 0;
      int v;
      for (int b = 5; b >= 0; b--) if (st[b]) k = b;
`ifdef TFI_DIF_EN
      v = (i % (1 << (5 - k))) << k;
`else
      v = (i % (1 << k)) << (5 - k);
`endif
      return 6'(v);
   endfunction

   task automatic push_seq(input logic [5:0] st, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.idx  = model(st, i);
         e.last = (i == 31);
         sb.push_back(e);
      end
   endtask

   // Called at posedge+1; start is sampled on the next rising edge.
   task automatic pulse_start(input logic [5:0] st);
      stage = st;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      tests++;
      assert (valid === 1'b0 && done === 1'b0 && out === 6'd0)
      else begin
         fails++;
         $error("FAIL %s: valid=%b done=%b out=%0d, want 0/0/0", tag, valid, done, out);
      end
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      tests++;
      assert (sb.size() === 0)
      else begin
         fails++;
         $error("FAIL %s drain: %0d entries left, want 0", tag, sb.size());
         sb.delete();
      end
      @(negedge clk);
      check_idle({tag, " after done"});
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (valid === 1'b1) begin
            tests++;
            assert (sb.size() != 0)
            else begin
               fails++;
               $error("FAIL unexpected valid: out=%0d done=%b, want no output", out, done);
            end
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               tests++;
               assert (out === e.idx && done === e.last)
               else begin
                  fails++;
                  $error("FAIL seq index: out=%0d done=%b, want out=%0d done=%b",
                         out, done, e.idx, e.last);
               end
            end
         end else begin
            tests++;
            assert (done === 1'b0)
            else begin
               fails++;
               $error("FAIL done without valid: done=%b, want 0", done);
            end
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset for one cycle, then five quiet cycles.
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_idle("reset");
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_idle("post reset idle");
      end
      @(posedge clk);
      #1;

      // Stage 3.
      push_seq(6'b001000, 32);
      pulse_start(6'b001000);
      drain("stage3");

      // Stage 0 started in the first idle cycle after the previous run.
      push_seq(6'b000001, 32);
      pulse_start(6'b000001);
      drain("stage0");

      // Stage 5 back-to-back.
      push_seq(6'b100000, 32);
      pulse_start(6'b100000);
      drain("stage5");

      // Multi-hot select: lowest bit (k=1) wins.
      push_seq(6'b001010, 32);
      pulse_start(6'b001010);
      drain("multihot");

      // Zero select: start ignored.
      pulse_start(6'b000000);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_idle("zero stage");
      end
      @(posedge clk);
      #1;

      // Second start at cycle 10 of a run is ignored.
      push_seq(6'b000100, 32);
      pulse_start(6'b000100);
      repeat (9) @(posedge clk);
      #1;
      pulse_start(6'b100000);
      drain("restart ignored");

      // Asynchronous reset at cycle 7 of a run.
      push_seq(6'b010000, 7);
      pulse_start(6'b010000);
      repeat (6) @(posedge clk);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_idle("async reset");
      tests++;
      assert (sb.size() === 0)
      else begin
         fails++;
         $error("FAIL reset abort count: %0d entries left, want 0", sb.size());
         sb.delete();
      end
      @(posedge clk);
      #1;
      check_idle("reset held");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_idle("after reset release");

      // Fresh start after reset restarts from i=0.
      push_seq(6'b010000, 32);
      pulse_start(6'b010000);
      drain("after reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/twiddle_factor_index.md
Name: twiddle_factor_index

Overview:
- Generates the twiddle-factor ROM index sequence for one radix-2 DIT FFT stage of an N = 2^LOG2N point transform (default 64).
- A `start` pulse latches a one-hot stage select. The block then emits N/2 indices, one per clock, addressing the shared twiddle ROM beside the butterfly datapath.
- The control FSM of the FFT core issues one start per stage.

Parameters:
- LOG2N, 6, log2 of FFT size. Sets the `stage` and `out` widths. Sequence length is 2^(LOG2N-1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset
- stage  input  LOG2N  one-hot stage select; bit k set selects stage k (span 2^k); sampled only when start is accepted
- start  input  1  single-cycle request to begin a stage sequence
- out  output  LOG2N  twiddle ROM index (registered)
- valid  output  1  out holds a sequence index this cycle
- done  output  1  high together with the last valid index of a sequence

Interface note: one clock; reset is asynchronous and active-high (clk, rst). All outputs are registered.

Behaviour:
- Reset (async, rst=1): FSM IDLE, counter i=0, out=0, valid=0, done=0. Reset mid-sequence aborts immediately. No resume after reset release.
- States: IDLE, RUN.
- IDLE -> RUN:
  - Transition occurs on a rising edge with start=1 and stage != 0.
  - Latch k = index of the lowest set bit of stage. Multi-hot stage uses the lowest bit; stage=0 means the start is ignored.
  - Clear i.
- RUN:
  - Each cycle: out = (i mod 2^k) << (LOG2N-1-k), valid=1, then i increments.
  - Output values lie in 0..N/2-1, so the MSB of out is always 0.
  - First valid index appears on the edge that accepts start, i.e. one cycle of latency.
  - Exactly 2^(LOG2N-1) valid cycles per sequence.
- Last index (i = N/2-1): done=1 for that cycle. The next edge returns the FSM to IDLE with valid=0, done=0, out=0.
- start while in RUN (including the done cycle) is ignored. stage changes during RUN are ignored.
- Back-to-back: a start arriving in the first IDLE cycle after done is accepted normally, giving one idle bubble between sequences.
- Counter arithmetic is unsigned, width LOG2N-1. Shift amount is LOG2N-1-k, range 0..LOG2N-1.

Optional Feature:
- Macro TFI_DIF_EN.
- Defined: decimation-in-frequency ordering, out = (i mod 2^(LOG2N-1-k)) << k. For N=64, stage 001000 gives 0,8,16,24,0,8,...
- Undefined: DIT formula above.
- Timing, handshake and sequence length are identical in both builds.

Decomposition:
- Package tfi_pkg:
  - LOG2N default constant
  - derived N_HALF constant
  - typedef tfi_idx_t (logic [LOG2N-1:0])
  - typedef tfi_state_e (IDLE, RUN)
- One sub-module, tfi_stage_encoder: combinational one-hot-to-binary priority encoder (lowest bit wins) plus a zero flag.

Test Plan:
- rst=1 for 1 cycle, then release with start=0 for 5 cycles -> out=0, valid=0, done=0 throughout.
- stage=6'b001000, start pulsed 1 cycle -> 32 valid cycles with out = 0,4,8,...,28 repeated 4 times; done only on the 32nd; valid=0 next cycle.
- stage=6'b000001 -> 32 valid cycles, all out=0. stage=6'b100000 -> out = 0,1,2,...,31.
- stage=6'b001010 (multi-hot) -> treated as k=1: out = 0,16,0,16,... for 32 cycles. stage=0 with start -> valid stays 0.
- Second start pulse at cycle 10 of a run -> ignored; sequence length remains 32, values unchanged.
- rst asserted at cycle 7 of a run -> out=0, valid=0 immediately (asynchronous). A fresh start after release restarts from i=0.
